// File: rtl/mcpu_alu.sv
// Registered 4-function ALU: AND, OR, XOR and unsigned ADD with carry-out.
// One result per clock, one cycle of latency, synchronous active-low reset.
module mcpu_alu #(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CMD_SIZE-1:0]  opcode,
  input  logic [WORD_SIZE-1:0] r1,
  input  logic [WORD_SIZE-1:0] r2,
  output logic [WORD_SIZE-1:0] out,
  output logic                 OVERFLOW
);

  localparam logic [CMD_SIZE-1:0] OP_AND = CMD_SIZE'(0);
  localparam logic [CMD_SIZE-1:0] OP_OR  = CMD_SIZE'(1);
  localparam logic [CMD_SIZE-1:0] OP_XOR = CMD_SIZE'(2);

  // Carry sits in the top bit; every opcode from 3 upward falls into the adder.
  logic [WORD_SIZE:0] result_next;

  always_comb begin
    result_next = '0;
    case (opcode)
      OP_AND:  result_next = {1'b0, r1 & r2};
      OP_OR:   result_next = {1'b0, r1 | r2};
      OP_XOR:  result_next = {1'b0, r1 ^ r2};
      default: result_next = {1'b0, r1} + {1'b0, r2};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out      <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      out      <= result_next[WORD_SIZE-1:0];
      OVERFLOW <= result_next[WORD_SIZE];
    end
  end

endmodule

// File: tb/tb_mcpu_alu.sv
// Directed bench for mcpu_alu: a 2-bit/2-bit-opcode instance and an
// 8-bit/3-bit-opcode instance sharing clock and reset.
module tb_mcpu_alu;

  logic       clk;
  logic       rst_n;
  logic [1:0] opcode;
  logic [1:0] r1;
  logic [1:0] r2;
  logic [1:0] out;
  logic       OVERFLOW;

  logic [2:0] opcode8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic [7:0] out8;
  logic       ovf8;

  int total;
  int bad;

  mcpu_alu #(.CMD_SIZE(2), .WORD_SIZE(2)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .r1(r1), .r2(r2),
    .out(out), .OVERFLOW(OVERFLOW)
  );

  mcpu_alu #(.CMD_SIZE(3), .WORD_SIZE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode8), .r1(a8), .r2(b8),
    .out(out8), .OVERFLOW(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 2'd3; r1 = 2'd3; r2 = 2'd3;
    opcode8 = 3'd3; a8 = 8'hFF; b8 = 8'hFF;
    step();
    step();
    total++;
    if (out !== 2'b00) begin bad++; $display("[TB] FAIL reset_out: got %b want 00", out); end
    total++;
    if (OVERFLOW !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b want 0", OVERFLOW); end
    total++;
    if (out8 !== 8'h00) begin bad++; $display("[TB] FAIL reset_out8: got %h want 00", out8); end
    total++;
    if (ovf8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf8: got %b want 0", ovf8); end
  endtask

  task automatic test_and();
    rst_n = 1'b1; opcode = 2'd0; r1 = 2'b11; r2 = 2'b10;
    step();
    total++;
    if (out !== 2'b10) begin bad++; $display("[TB] FAIL and_out: got %b want 10", out); end
    total++;
    if (OVERFLOW !== 1'b0) begin bad++; $display("[TB] FAIL and_ovf: got %b want 0", OVERFLOW); end
  endtask

  task automatic test_or_xor();
    opcode = 2'd1; r1 = 2'b01; r2 = 2'b10;
    step();
    total++;
    if (out !== 2'b11) begin bad++; $display("[TB] FAIL or_out: got %b want 11", out); end
    total++;
    if (OVERFLOW !== 1'b0) begin bad++; $display("[TB] FAIL or_ovf: got %b want 0", OVERFLOW); end
    opcode = 2'd2; r1 = 2'b11; r2 = 2'b01;
    step();
    total++;
    if (out !== 2'b10) begin bad++; $display("[TB] FAIL xor_out: got %b want 10", out); end
    total++;
    if (OVERFLOW !== 1'b0) begin bad++; $display("[TB] FAIL xor_ovf: got %b want 0", OVERFLOW); end
  endtask

  task automatic test_add();
    opcode = 2'd3; r1 = 2'b11; r2 = 2'b01;
    step();
    total++;
    if (out !== 2'b00) begin bad++; $display("[TB] FAIL add_carry_out: got %b want 00", out); end
    total++;
    if (OVERFLOW !== 1'b1) begin bad++; $display("[TB] FAIL add_carry_ovf: got %b want 1", OVERFLOW); end
    r1 = 2'b01; r2 = 2'b01;
    step();
    total++;
    if (out !== 2'b10) begin bad++; $display("[TB] FAIL add_plain_out: got %b want 10", out); end
    total++;
    if (OVERFLOW !== 1'b0) begin bad++; $display("[TB] FAIL add_plain_ovf: got %b want 0", OVERFLOW); end
  endtask

  task automatic test_reset_priority();
    opcode = 2'd3; r1 = 2'd3; r2 = 2'd3;
    step();
    total++;
    if ({OVERFLOW, out} !== 3'b110) begin bad++; $display("[TB] FAIL prio_pre: got %b want 110", {OVERFLOW, out}); end
    rst_n = 1'b0;
    step();
    total++;
    if ({OVERFLOW, out} !== 3'b000) begin bad++; $display("[TB] FAIL prio_reset: got %b want 000", {OVERFLOW, out}); end
    rst_n = 1'b1;
    step();
    total++;
    if ({OVERFLOW, out} !== 3'b110) begin bad++; $display("[TB] FAIL prio_release: got %b want 110", {OVERFLOW, out}); end
  endtask

  task automatic test_hold();
    opcode = 2'd0; r1 = 2'd0; r2 = 2'd0;
    #3;
    total++;
    if ({OVERFLOW, out} !== 3'b110) begin bad++; $display("[TB] FAIL hold_between_edges: got %b want 110", {OVERFLOW, out}); end
    step();
    total++;
    if ({OVERFLOW, out} !== 3'b000) begin bad++; $display("[TB] FAIL hold_next_edge: got %b want 000", {OVERFLOW, out}); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] v_op  [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [1:0] v_r1  [10] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd3};
    logic [1:0] v_r2  [10] = '{2'd3, 2'd0, 2'd3, 2'd2, 2'd2, 2'd1, 2'd0, 2'd3, 2'd0, 2'd0};
    logic [2:0] v_exp [10] = '{3'b001, 3'b000, 3'b000, 3'b100, 3'b011,
                               3'b000, 3'b010, 3'b010, 3'b000, 3'b011};
    for (int i = 0; i < 10; i++) begin
      opcode = v_op[i]; r1 = v_r1[i]; r2 = v_r2[i];
      step();
      total++;
      if ({OVERFLOW, out} !== v_exp[i]) begin
        bad++;
        $display("[TB] FAIL b2b_%0d: got %b want %b", i, {OVERFLOW, out}, v_exp[i]);
      end
    end
  endtask

  task automatic test_default_range();
    logic [2:0] v_op  [5] = '{3'b101, 3'b111, 3'b100, 3'b010, 3'b011};
    logic [7:0] v_a   [5] = '{8'hFF, 8'h80, 8'h12, 8'hF0, 8'h7F};
    logic [7:0] v_b   [5] = '{8'h01, 8'h80, 8'h34, 8'hFF, 8'h01};
    logic [8:0] v_exp [5] = '{9'h100, 9'h100, 9'h046, 9'h00F, 9'h080};
    for (int i = 0; i < 5; i++) begin
      opcode8 = v_op[i]; a8 = v_a[i]; b8 = v_b[i];
      step();
      total++;
      if ({ovf8, out8} !== v_exp[i]) begin
        bad++;
        $display("[TB] FAIL wide_%0d: got %h want %h", i, {ovf8, out8}, v_exp[i]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_and();
    test_or_xor();
    test_add();
    test_reset_priority();
    test_hold();
    test_back_to_back();
    test_default_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
